// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage that sits directly in front of the memory
//   controller's instruction port. It holds the PC and issues one fetch per
//   access. Each access takes MEM_LAT cycles, counting the FETCH cycle. The
//   returned word goes to decode through a one-entry valid/stall register as
//   {instr, pc, pc+4}. A branch redirect from execute flushes the fetch that
//   is in flight and also flushes the output register.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   if_mc_en      fetch request to the memory controller
//   if_mc_addr    byte address of the current fetch (word aligned)
//   mc_if_data    instruction word returned by the memory controller
//   id_if_stall   decode cannot accept if_id_* this cycle
//   ex_if_branch  one-cycle redirect request
//   ex_if_target  redirect byte address (low two bits are ignored)
//   if_id_valid   if_id_* hold a valid instruction
//   if_id_instr   fetched instruction (NOP after reset or flush)
//   if_id_pc      address of if_id_instr
//   if_id_pc4     if_id_pc + 4, wrapping at 2^ADDR_W
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 18,
    parameter int                DATA_W   = 32,
    parameter int                MEM_LAT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP      = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              if_mc_en,
    output logic [ADDR_W-1:0] if_mc_addr,
    input  logic [DATA_W-1:0] mc_if_data,
    input  logic              id_if_stall,
    input  logic              ex_if_branch,
    input  logic [ADDR_W-1:0] ex_if_target,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4
);

    // cnt_reg counts the WAIT cycles that remain before the sample cycle.
    // The FETCH cycle is the first cycle of the access, so it loads
    // MEM_LAT-2. When MEM_LAT==1, FETCH is already the sample cycle.
    localparam int CNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam int CNT_INIT = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CNT_INIT);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
    localparam bit                FETCH_SMP = (MEM_LAT == 1);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic                valid_reg;
    logic [DATA_W-1:0]   instr_reg;
    logic [ADDR_W-1:0]   id_pc_reg;
    logic [ADDR_W-1:0]   id_pc4_reg;

    logic                out_free;
    logic                sample;
    logic                capture;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [ADDR_W-1:0]   target_aligned;

    assign pc_plus4       = pc_reg + PC_STEP;
    assign target_aligned = {ex_if_target[ADDR_W-1:2], 2'b00};
    assign out_free       = !valid_reg || !id_if_stall;
    assign sample         = ((state_reg == ST_WAIT) && (cnt_reg == '0)) ||
                            ((state_reg == ST_FETCH) && FETCH_SMP);
    assign capture        = sample && out_free;

    // The unit is always either presenting or waiting on an address, so the
    // request is active whenever reset is not asserted.
    assign if_mc_en    = reset;
    assign if_mc_addr  = pc_reg;
    assign if_id_valid = valid_reg;
    assign if_id_instr = instr_reg;
    assign if_id_pc    = id_pc_reg;
    assign if_id_pc4   = id_pc4_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= ST_FETCH;
            cnt_reg    <= '0;
            pc_reg     <= RESET_PC;
            valid_reg  <= 1'b0;
            instr_reg  <= NOP;
            id_pc_reg  <= RESET_PC;
            id_pc4_reg <= RESET_PC + PC_STEP;
        end else if (ex_if_branch) begin
            // A redirect overrides any capture this cycle and also flushes
            // the output register, even when decode is stalled.
            state_reg <= ST_FETCH;
            cnt_reg   <= '0;
            pc_reg    <= target_aligned;
            valid_reg <= 1'b0;
            instr_reg <= NOP;
        end else if (capture) begin
            instr_reg  <= mc_if_data;
            id_pc_reg  <= pc_reg;
            id_pc4_reg <= pc_plus4;
            valid_reg  <= 1'b1;
            pc_reg     <= pc_plus4;
            state_reg  <= ST_FETCH;
            cnt_reg    <= '0;
        end else begin
            // Decode takes the entry and nothing replaces it this edge.
            if (valid_reg && !id_if_stall) begin
                valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_FETCH: begin
                    // With MEM_LAT==1, a blocked FETCH goes here and waits
                    // at cnt==0. The address does not change.
                    state_reg <= ST_WAIT;
                    cnt_reg   <= CNT_LOAD;
                end
                ST_WAIT: begin
                    // At cnt==0 with the output blocked, hold here. The
                    // memory keeps returning the same word.
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_FETCH;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Two instances share the clock and reset. dut_a uses RESET_PC=0 and a
//   NOP value that is easy to recognise. dut_b uses RESET_PC=3FFFC and
//   exercises the wrap of the PC. Each memory returns {14'h0, addr}.
//   Expected deliveries go into a queue per instance. A monitor pops one
//   entry each time decode accepts an instruction (valid && !stall at the
//   edge) and compares it.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP_A = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [17:0] pc;
        logic [17:0] pc4;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        stall_a, stall_b;
    logic        branch;
    logic [17:0] target;

    logic        en_a, en_b;
    logic [17:0] addr_a, addr_b;
    logic [31:0] mc_data_a, mc_data_b;
    logic        valid_a, valid_b;
    logic [31:0] instr_a, instr_b;
    logic [17:0] pc_a, pc_b, pc4_a, pc4_b;
    logic        branch_b;
    logic [17:0] target_b;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    assign mc_data_a = {14'h0, addr_a};
    assign mc_data_b = {14'h0, addr_b};
    assign branch_b  = 1'b0;
    assign target_b  = 18'h0;

    fetch_unit #(
        .ADDR_W(18), .DATA_W(32), .MEM_LAT(2),
        .RESET_PC(18'h00000), .NOP(NOP_A)
    ) dut_a (
        .clock(clock), .reset(reset),
        .if_mc_en(en_a), .if_mc_addr(addr_a), .mc_if_data(mc_data_a),
        .id_if_stall(stall_a), .ex_if_branch(branch), .ex_if_target(target),
        .if_id_valid(valid_a), .if_id_instr(instr_a),
        .if_id_pc(pc_a), .if_id_pc4(pc4_a)
    );

    fetch_unit #(
        .ADDR_W(18), .DATA_W(32), .MEM_LAT(2),
        .RESET_PC(18'h3FFFC), .NOP(32'h0)
    ) dut_b (
        .clock(clock), .reset(reset),
        .if_mc_en(en_b), .if_mc_addr(addr_b), .mc_if_data(mc_data_b),
        .id_if_stall(stall_b), .ex_if_branch(branch_b), .ex_if_target(target_b),
        .if_id_valid(valid_b), .if_id_instr(instr_b),
        .if_id_pc(pc_b), .if_id_pc4(pc4_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [17:0] pc);
        exp_t e;
        e.instr = {14'h0, pc};
        e.pc    = pc;
        e.pc4   = pc + 18'd4;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [17:0] pc);
        exp_t e;
        e.instr = {14'h0, pc};
        e.pc    = pc;
        e.pc4   = pc + 18'd4;
        q_b.push_back(e);
    endtask

    // Monitor: decode accepts an entry at the next edge when valid && !stall.
    always @(negedge clock) begin
        exp_t e;
        if (valid_a && !stall_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_delivery", {46'h0, pc_a}, 64'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                $display("txn a pc=%05h pc4=%05h instr=%08h", pc_a, pc4_a, instr_a);
                check("a_sb_pc", {46'h0, pc_a}, {46'h0, e.pc});
                check("a_sb_pc4", {46'h0, pc4_a}, {46'h0, e.pc4});
                check("a_sb_instr", {32'h0, instr_a}, {32'h0, e.instr});
            end
        end
        if (valid_b && !stall_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_delivery", {46'h0, pc_b}, 64'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                $display("txn b pc=%05h pc4=%05h instr=%08h", pc_b, pc4_b, instr_b);
                check("b_sb_pc", {46'h0, pc_b}, {46'h0, e.pc});
                check("b_sb_pc4", {46'h0, pc4_b}, {46'h0, e.pc4});
                check("b_sb_instr", {32'h0, instr_b}, {32'h0, e.instr});
            end
        end
    end

    initial begin
        reset   = 1'b0;
        stall_a = 1'b0;
        stall_b = 1'b0;
        branch  = 1'b0;
        target  = 18'h0;

        repeat (3) tick();
        check("rst_valid", {63'h0, valid_a}, 64'h0);
        check("rst_instr", {32'h0, instr_a}, {32'h0, NOP_A});
        check("rst_pc", {46'h0, pc_a}, 64'h0);
        check("rst_pc4", {46'h0, pc4_a}, 64'h4);
        check("rst_en", {63'h0, en_a}, 64'h0);
        check("rst_b_pc", {46'h0, pc_b}, 64'h3FFFC);
        check("rst_b_pc4", {46'h0, pc4_b}, 64'h0);

        // Run from reset. dut_b covers the PC wrap.
        push_a(18'h00000); push_a(18'h00004);
        push_b(18'h3FFFC); push_b(18'h00000);
        reset = 1'b1;
        #1;
        check("run_en", {63'h0, en_a}, 64'h1);
        check("run_addr", {46'h0, addr_a}, 64'h0);
        check("b_addr0", {46'h0, addr_b}, 64'h3FFFC);
        tick();                                             // E1
        check("e1_valid", {63'h0, valid_a}, 64'h0);
        tick();                                             // E2
        check("e2_valid", {63'h0, valid_a}, 64'h1);
        check("e2_pc", {46'h0, pc_a}, 64'h0);
        check("e2_pc4", {46'h0, pc4_a}, 64'h4);
        check("b_first_pc", {46'h0, pc_b}, 64'h3FFFC);
        check("b_first_pc4", {46'h0, pc4_b}, 64'h0);
        tick();                                             // E3
        check("e3_valid", {63'h0, valid_a}, 64'h0);
        check("e3_addr", {46'h0, addr_a}, 64'h4);
        check("b_second_addr", {46'h0, addr_b}, 64'h0);
        tick();                                             // E4
        check("e4_valid", {63'h0, valid_a}, 64'h1);
        check("e4_pc", {46'h0, pc_a}, 64'h4);

        // Hold the stall for five edges. The output and address freeze.
        push_a(18'h00008);
        stall_a = 1'b1;
        tick();                                             // E5
        stall_b = 1'b1;
        check("stall_valid", {63'h0, valid_a}, 64'h1);
        check("stall_addr", {46'h0, addr_a}, 64'h8);
        for (int i = 0; i < 4; i++) begin                   // E6..E9
            tick();
            check("stall_valid", {63'h0, valid_a}, 64'h1);
            check("stall_pc", {46'h0, pc_a}, 64'h4);
            check("stall_instr", {32'h0, instr_a}, 64'h4);
            check("stall_addr", {46'h0, addr_a}, 64'h8);
        end
        stall_a = 1'b0;
        tick();                                             // E10
        check("unstall_valid", {63'h0, valid_a}, 64'h1);
        check("unstall_pc", {46'h0, pc_a}, 64'h8);
        tick();                                             // E11
        check("e11_valid", {63'h0, valid_a}, 64'h0);
        check("e11_addr", {46'h0, addr_a}, 64'hC);

        // Branch while in WAIT to an unaligned target.
        push_a(18'h00100);
        branch = 1'b1;
        target = 18'h00103;
        tick();                                             // E12
        branch = 1'b0;
        check("br1_valid", {63'h0, valid_a}, 64'h0);
        check("br1_instr", {32'h0, instr_a}, {32'h0, NOP_A});
        check("br1_addr", {46'h0, addr_a}, 64'h100);
        tick();                                             // E13
        check("br1_wait_valid", {63'h0, valid_a}, 64'h0);
        tick();                                             // E14
        check("br1_tgt_valid", {63'h0, valid_a}, 64'h1);
        check("br1_tgt_pc", {46'h0, pc_a}, 64'h100);
        tick();                                             // E15
        check("e15_addr", {46'h0, addr_a}, 64'h104);

        // Branch on the sample cycle. The word for 0x104 is dropped.
        push_a(18'h00040);
        branch = 1'b1;
        target = 18'h00040;
        tick();                                             // E16
        branch = 1'b0;
        check("br2_valid", {63'h0, valid_a}, 64'h0);
        check("br2_instr", {32'h0, instr_a}, {32'h0, NOP_A});
        check("br2_addr", {46'h0, addr_a}, 64'h40);
        tick();                                             // E17
        tick();                                             // E18
        check("br2_tgt_valid", {63'h0, valid_a}, 64'h1);
        check("br2_tgt_pc", {46'h0, pc_a}, 64'h40);
        tick();                                             // E19
        tick();                                             // E20
        check("e20_pc", {46'h0, pc_a}, 64'h44);

        // Reset during WAIT while the output is valid and stalled.
        stall_a = 1'b1;
        tick();                                             // E21
        check("pre_rst_valid", {63'h0, valid_a}, 64'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_en", {63'h0, en_a}, 64'h0);
        tick();                                             // E22
        reset   = 1'b1;
        stall_a = 1'b0;
        check("rst2_valid", {63'h0, valid_a}, 64'h0);
        check("rst2_instr", {32'h0, instr_a}, {32'h0, NOP_A});
        check("rst2_pc", {46'h0, pc_a}, 64'h0);
        check("rst2_pc4", {46'h0, pc4_a}, 64'h4);
        check("rst2_addr", {46'h0, addr_a}, 64'h0);
        check("rst2_b_valid", {63'h0, valid_b}, 64'h0);
        check("rst2_b_addr", {46'h0, addr_b}, 64'h3FFFC);

        push_a(18'h00000); push_a(18'h00004);
        tick();                                             // E23
        tick();                                             // E24
        check("post_rst_pc", {46'h0, pc_a}, 64'h0);
        // A low pulse on reset between edges must not change anything.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        check("glitch_valid", {63'h0, valid_a}, 64'h1);
        check("glitch_pc", {46'h0, pc_a}, 64'h0);
        tick();                                             // E25
        check("glitch_addr", {46'h0, addr_a}, 64'h4);
        tick();                                             // E26
        check("glitch_next_pc", {46'h0, pc_a}, 64'h4);
        check("glitch_next_pc4", {46'h0, pc4_a}, 64'h8);

        @(negedge clock);
        #1;
        check("a_queue_drained", 64'(q_a.size()), 64'h0);
        check("b_queue_drained", 64'(q_b.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
